// File: rtl/usb_eop_timer.sv
// End-of-packet timer: after an accepted EOP, counts DATA_DLY bit strobes, pulses
// data_ready, counts DONE_DLY further strobes, then pulses enc_done.
module usb_eop_timer #(
  parameter int CNT_W     = 4,
  parameter int DATA_DLY  = 10,
  parameter int DONE_DLY  = 10,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             EOP_flag,
  input  logic             abort,
  output logic             data_ready,
  output logic             enc_done,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    DATA_RDY  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DATA_TERM = CNT_W'(DATA_DLY - 1);
  localparam logic [CNT_W-1:0] DONE_TERM = CNT_W'(DONE_DLY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ovr_q, ovr_nxt;
  logic             in_flight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      ovr_q <= ovr_nxt;
    end
  end

  // DONE is excluded: an EOP there starts the next sequence without overrun.
  assign in_flight = (state == WAIT_DATA) || (state == DATA_RDY) || (state == WAIT_DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    ovr_nxt   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (EOP_flag) state_nxt = WAIT_DATA;
        end
        WAIT_DATA: begin
          if (bit_en) begin
            if (cnt_q == DATA_TERM) begin
              state_nxt = DATA_RDY;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
        end
        DATA_RDY: begin
          state_nxt = WAIT_DONE;
          cnt_nxt   = '0;
        end
        WAIT_DONE: begin
          if (bit_en) begin
            if (cnt_q == DONE_TERM) begin
              state_nxt = DONE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          cnt_nxt   = '0;
          state_nxt = EOP_flag ? WAIT_DATA : IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      if (EOP_flag && in_flight) begin
        if (RETRIGGER != 0) begin
          state_nxt = WAIT_DATA;
          cnt_nxt   = '0;
        end else begin
          ovr_nxt = 1'b1;
        end
      end
    end
  end

  // Pulses are state-decoded but suppressed in an abort cycle.
  always_comb begin
    data_ready = (state == DATA_RDY) && !abort;
    enc_done   = (state == DONE) && !abort;
    busy       = (state != IDLE);
    overrun    = ovr_q;
    count      = cnt_q;
  end

endmodule

// File: tb/tb_usb_eop_timer.sv
// Bench for usb_eop_timer: three instances share stimulus and are checked every cycle
// against a timeline-position model, plus vector tables and corner-case sequences.
module tb_usb_eop_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       eop;
  logic       abort;
  logic [2:0] dr_w, done_w, busy_w, ovr_w;
  logic [3:0] cnt_w [3];

  always #5 clk = ~clk;

  usb_eop_timer u_def (
    .clk(clk), .rst(rst), .bit_en(bit_en), .EOP_flag(eop), .abort(abort),
    .data_ready(dr_w[0]), .enc_done(done_w[0]), .busy(busy_w[0]),
    .overrun(ovr_w[0]), .count(cnt_w[0])
  );

  usb_eop_timer #(.RETRIGGER(1)) u_ret (
    .clk(clk), .rst(rst), .bit_en(bit_en), .EOP_flag(eop), .abort(abort),
    .data_ready(dr_w[1]), .enc_done(done_w[1]), .busy(busy_w[1]),
    .overrun(ovr_w[1]), .count(cnt_w[1])
  );

  usb_eop_timer #(.DATA_DLY(3), .DONE_DLY(2), .RETRIGGER(1)) u_sml (
    .clk(clk), .rst(rst), .bit_en(bit_en), .EOP_flag(eop), .abort(abort),
    .data_ready(dr_w[2]), .enc_done(done_w[2]), .busy(busy_w[2]),
    .overrun(ovr_w[2]), .count(cnt_w[2])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: position on the sequence timeline. -1 idle, 0..dd-1 counting to data_ready,
  // dd is the data_ready cycle, dd+1..dd+dn counting to enc_done, dd+dn+1 the enc_done cycle.
  int pos [3];
  bit ovr [3];
  int dd  [3] = '{10, 10, 3};
  int dn  [3] = '{10, 10, 2};
  bit rt  [3] = '{1'b0, 1'b1, 1'b1};

  logic [2:0] s_dr, s_done, s_busy, s_ovr;
  logic [3:0] s_cnt [3];

  typedef struct {
    int inst;
    int eop_cyc;
    int period;
    int dr;
    int done;
    int b_first;
    int b_last;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, inst, cyc, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int i);
    int last;
    last = dd[i] + dn[i] + 1;
    if (pos[i] < 0) return 0;
    if (pos[i] < dd[i]) return pos[i];
    if (pos[i] > dd[i] && pos[i] < last) return pos[i] - dd[i] - 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = -1;
      ovr[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int last;
      last = dd[i] + dn[i] + 1;
      if (!rst || abort) begin
        pos[i] = -1;
        ovr[i] = 1'b0;
      end else begin
        ovr[i] = 1'b0;
        if (pos[i] < 0 || pos[i] == last) pos[i] = eop ? 0 : -1;
        else if (eop && rt[i]) pos[i] = 0;
        else begin
          if (eop) ovr[i] = 1'b1;
          if (pos[i] == dd[i] || bit_en) pos[i] = pos[i] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("data_ready", i, int'(dr_w[i]), int'(pos[i] == dd[i] && !abort));
      chk("enc_done", i, int'(done_w[i]), int'(pos[i] == dd[i] + dn[i] + 1 && !abort));
      chk("busy", i, int'(busy_w[i]), int'(pos[i] >= 0));
      chk("overrun", i, int'(ovr_w[i]), int'(ovr[i]));
      chk("count", i, int'(cnt_w[i]), exp_cnt(i));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    s_dr = dr_w; s_done = done_w; s_busy = busy_w; s_ovr = ovr_w;
    for (int i = 0; i < 3; i++) s_cnt[i] = cnt_w[i];
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic settle();
    eop = 1'b0; bit_en = 1'b0; abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int f_dr, n_dr, f_done, n_done, b_first, b_last;
    settle();
    f_dr = -1; n_dr = 0; f_done = -1; n_done = 0; b_first = -1; b_last = -1;
    for (int c = 0; c < 60; c++) begin
      eop    = (c == v.eop_cyc);
      bit_en = ((c % v.period) == (v.period - 1));
      abort  = 1'b0;
      cycle();
      if (s_dr[v.inst]) begin n_dr++; if (f_dr < 0) f_dr = c; end
      if (s_done[v.inst]) begin n_done++; if (f_done < 0) f_done = c; end
      if (s_busy[v.inst]) begin if (b_first < 0) b_first = c; b_last = c; end
    end
    chk("vec_dr_cycle", v.inst, f_dr, v.dr);
    chk("vec_dr_pulses", v.inst, n_dr, 1);
    chk("vec_done_cycle", v.inst, f_done, v.done);
    chk("vec_done_pulses", v.inst, n_done, 1);
    chk("vec_busy_first", v.inst, b_first, v.b_first);
    chk("vec_busy_last", v.inst, b_last, v.b_last);
  endtask

  initial begin
    int n_ov0, ov0_cyc, done0_cyc, n_dr1, last_dr1, n_ov1, cnt1_16;
    int n_dr0, n_done0, busy0_12, busy0_23, dr0_last, n_busy;
    vecs[0] = '{inst: 0, eop_cyc: 5, period: 1, dr: 16, done: 27, b_first: 6, b_last: 27};
    vecs[1] = '{inst: 2, eop_cyc: 0, period: 1, dr: 4,  done: 7,  b_first: 1, b_last: 7};
    vecs[2] = '{inst: 2, eop_cyc: 0, period: 4, dr: 12, done: 20, b_first: 1, b_last: 20};
    vecs[3] = '{inst: 0, eop_cyc: 0, period: 2, dr: 20, done: 40, b_first: 1, b_last: 40};
    vecs[4] = '{inst: 1, eop_cyc: 2, period: 1, dr: 13, done: 24, b_first: 3, b_last: 24};
    vecs[5] = '{inst: 2, eop_cyc: 1, period: 3, dr: 9,  done: 15, b_first: 2, b_last: 15};

    rst = 1'b0; eop = 1'b0; bit_en = 1'b0; abort = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Second EOP while in WAIT_DONE: overrun without retrigger, restart with it.
    settle();
    n_ov0 = 0; ov0_cyc = -1; done0_cyc = -1; n_dr1 = 0; last_dr1 = -1; n_ov1 = 0; cnt1_16 = -1;
    for (int c = 0; c < 45; c++) begin
      eop = (c == 0 || c == 15); bit_en = 1'b1;
      cycle();
      if (s_ovr[0]) begin n_ov0++; ov0_cyc = c; end
      if (s_done[0] && done0_cyc < 0) done0_cyc = c;
      if (s_dr[1]) begin n_dr1++; last_dr1 = c; end
      if (s_ovr[1]) n_ov1++;
      if (c == 16) cnt1_16 = int'(s_cnt[1]);
    end
    chk("ovr_pulses", 0, n_ov0, 1);
    chk("ovr_cycle", 0, ov0_cyc, 16);
    chk("ovr_done_cycle", 0, done0_cyc, 22);
    chk("retrig_count", 1, cnt1_16, 0);
    chk("retrig_dr_pulses", 1, n_dr1, 2);
    chk("retrig_dr_cycle", 1, last_dr1, 26);
    chk("retrig_no_ovr", 1, n_ov1, 0);

    // Abort together with EOP in the data_ready cycle.
    settle();
    n_dr0 = 0; n_done0 = 0; n_ov0 = 0; busy0_12 = -1;
    for (int c = 0; c < 40; c++) begin
      eop = (c == 0 || c == 11); abort = (c == 11); bit_en = 1'b1;
      cycle();
      if (s_dr[0]) n_dr0++;
      if (s_done[0]) n_done0++;
      if (s_ovr[0]) n_ov0++;
      if (c == 12) busy0_12 = int'(s_busy[0]);
    end
    abort = 1'b0;
    chk("abort_no_dr", 0, n_dr0, 0);
    chk("abort_no_done", 0, n_done0, 0);
    chk("abort_no_ovr", 0, n_ov0, 0);
    chk("abort_busy_after", 0, busy0_12, 0);

    // EOP exactly in the DONE cycle: back-to-back sequences.
    settle();
    done0_cyc = -1; busy0_23 = -1; dr0_last = -1; n_ov0 = 0;
    for (int c = 0; c < 50; c++) begin
      eop = (c == 0 || c == 22); bit_en = 1'b1;
      cycle();
      if (s_done[0] && done0_cyc < 0) done0_cyc = c;
      if (c == 23) busy0_23 = int'(s_busy[0]);
      if (s_dr[0]) dr0_last = c;
      if (s_ovr[0]) n_ov0++;
    end
    chk("b2b_done_cycle", 0, done0_cyc, 22);
    chk("b2b_busy_held", 0, busy0_23, 1);
    chk("b2b_second_dr", 0, dr0_last, 33);
    chk("b2b_no_ovr", 0, n_ov0, 0);

    // Asynchronous reset in the middle of WAIT_DATA.
    settle();
    for (int c = 0; c < 7; c++) begin
      eop = (c == 0); bit_en = 1'b1;
      cycle();
    end
    @(negedge clk);
    check_all();
    chk("pre_reset_count", 0, int'(cnt_w[0]), 6);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_reset_busy", 0, int'(busy_w[0]), 0);
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    cycle();
    rst = 1'b1;
    n_busy = 0;
    for (int c = 0; c < 20; c++) begin
      eop = 1'b0; bit_en = 1'b1;
      cycle();
      if (s_busy[0]) n_busy++;
    end
    chk("post_reset_idle", 0, n_busy, 0);

    // Randomized traffic against the model.
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = $urandom_range(1, 4);
      for (int c = 0; c < 500; c++) begin
        eop    = ($urandom_range(0, 11) == 0);
        bit_en = ($urandom_range(1, 4) <= dens);
        abort  = ($urandom_range(0, 59) == 0);
        cycle();
      end
    end
    abort = 1'b0;
    eop   = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_eop_timer.md
# usb_eop_timer

Parametrised end-of-packet timer for the USB transmit/receive path. After an `EOP_flag` it counts a programmable number of bit strobes, pulses `data_ready`, counts a second programmable number of strobes, then pulses `enc_done`. It adds three things: a bit-rate strobe input, so counting follows the bit clock rather than every system clock; an abort input; and a selectable retrigger/overrun policy for an EOP that arrives while a sequence is in flight. It sits between the EOP detector and the encoder/receive-buffer control logic.

## Interface
- `CNT_W`, 4: width of the strobe counter.
- `DATA_DLY`, 10: bit strobes from EOP acceptance to `data_ready`. Legal range is 1..2^CNT_W-1.
- `DONE_DLY`, 10: bit strobes from the end of the `data_ready` cycle to `enc_done`. Legal range is 1..2^CNT_W-1.
- `RETRIGGER`, 0: EOP policy while busy.
  - 1: restart the sequence.
  - 0: ignore the EOP and flag `overrun`.

- `clk`  in  1  system clock. All state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bit_en`  in  1  bit-period strobe. Only cycles with `bit_en`=1 advance the counter.
- `EOP_flag`  in  1  end-of-packet indication, sampled every clock.
- `abort`  in  1  synchronous cancel of any sequence in flight.
- `data_ready`  out  1  one-cycle pulse after `DATA_DLY` strobes.
- `enc_done`  out  1  one-cycle pulse after a further `DONE_DLY` strobes.
- `busy`  out  1  high whenever the state is not IDLE.
- `overrun`  out  1  one-cycle pulse when an EOP is dropped. Only possible when `RETRIGGER`=0.
- `count`  out  CNT_W  current counter value, for debug and status.

## Operation
- States: IDLE, WAIT_DATA, DATA_RDY, WAIT_DONE, DONE.
- Outputs are Moore-decoded from the state register:
  - `data_ready`=1 only in DATA_RDY.
  - `enc_done`=1 only in DONE.
  - `busy`=(state≠IDLE).
  - `overrun` is a registered pulse.
- IDLE:
  - `EOP_flag`=1 → WAIT_DATA, `count`←0.
  - Otherwise stay, `count` holds 0.
- WAIT_DATA:
  - On `bit_en`, `count`←`count`+1.
  - When `bit_en`=1 and `count`=`DATA_DLY`-1 → DATA_RDY, `count`←0.
- DATA_RDY: lasts exactly one cycle → WAIT_DONE. `bit_en` in this cycle is not counted.
- WAIT_DONE: same counting rule as WAIT_DATA, against `DONE_DLY`-1 → DONE, `count`←0.
- DONE: lasts one cycle → IDLE. If `EOP_flag`=1 in this cycle → WAIT_DATA instead, for either `RETRIGGER` value, and `overrun` stays 0.
- EOP in WAIT_DATA, DATA_RDY or WAIT_DONE:
  - `RETRIGGER`=1 → WAIT_DATA, `count`←0. The current state's output pulse, if any, is still emitted this cycle.
  - `RETRIGGER`=0 → state and count advance normally; `overrun`=1 next cycle.
- `abort`=1 has top priority after reset:
  - Any state → IDLE, `count`←0.
  - A concurrent EOP is dropped with no `overrun`.
  - `data_ready`/`enc_done` are forced to 0 in the abort cycle.
- Counter never wraps: it is cleared on reaching its terminal value, so width `CNT_W` suffices for legal parameters.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `count`=0, `data_ready`=`enc_done`=`busy`=`overrun`=0. Release is synchronous to the next `clk` edge.
- With `bit_en` held at 1 and EOP sampled at edge E:
  - `busy` rises after E.
  - `data_ready` is high in cycle E+`DATA_DLY`+1.
  - `enc_done` is high in cycle E+`DATA_DLY`+`DONE_DLY`+2.
  - `busy` falls after the `enc_done` cycle.
- With `bit_en` every Nth cycle, the latency is measured in strobes. The terminal strobe's edge moves the state on, and the pulse appears the cycle after that edge.
- `overrun` is asserted the cycle after the dropped EOP and lasts one cycle.
- Back-to-back: an EOP in the DONE cycle gives zero idle cycles between sequences.

## Test plan
- Defaults, `bit_en`=1, one-cycle EOP at cycle 5 → `data_ready` only in cycle 16, `enc_done` only in cycle 27, `busy` high in cycles 6–27.
- `bit_en` every 4th cycle, `DATA_DLY`=3, `DONE_DLY`=2 → `data_ready` one cycle after the 3rd strobe following EOP, `enc_done` one cycle after the 2nd strobe after that. `count` visibly steps 0,1,2 between strobes.
- `RETRIGGER`=0, second EOP while in WAIT_DONE → `overrun` pulses once, `enc_done` timing unchanged. With `RETRIGGER`=1, the same stimulus → `count`=0, WAIT_DATA restarts, the next `data_ready` is `DATA_DLY`+1 cycles after the second EOP.
- `abort` together with EOP in the cycle `data_ready` would assert → no `data_ready`, `busy`=0 next cycle, no `overrun`, no later pulses.
- EOP exactly in the DONE cycle → `enc_done`=1 that cycle, `busy` stays 1, a new `data_ready` follows `DATA_DLY`+1 cycles later, `overrun`=0.
- `rst` asserted mid-WAIT_DATA with `count`=6 → all outputs 0 immediately, without waiting for `clk`. After release, the module idles until the next EOP.
